paralelo_serie_tx: RTL and testbench
====================================

PARALELO_SERIE_TX -- requirements
Module: paralelo_serie_tx

Interface
REQ-001 Parameter: SYNC_COMMAS, 4, number of 0xBC comma bytes sent after reset before data may be serialized (legal range 1..7).
REQ-002 Port: clk_8f  input  1  bit clock; one serial bit per rising edge; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk_8f.
REQ-004 Port: in_data  input  8  parallel byte to transmit.
REQ-005 Port: in_valid  input  1  in_data holds a byte to be accepted.
REQ-006 Port: in_ready  output  1  block can accept a byte this cycle.
REQ-007 Port: data_out  output  1  registered serial stream, MSB first.
REQ-008 Port: synced  output  1  high once SYNC_COMMAS commas have been sent (state ACTIVE).
REQ-009 Port: byte_sent  output  1  one-cycle pulse when a FIFO data byte is loaded for serialization.

Function
REQ-010 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; the byte SHALL be written to a 2-entry FIFO.
REQ-011 in_ready SHALL equal (FIFO occupancy < 2), combinationally from registered occupancy; pushes are accepted in both SYNC and ACTIVE.
REQ-012 Internal state: cur_byte[7:0], bit_idx[2:0] (counts 7 down to 0), comma_cnt[2:0], state in {SYNC, ACTIVE}.
REQ-013 On each non-reset edge, data_out SHALL be loaded with cur_byte[bit_idx].
REQ-014 If bit_idx != 0, bit_idx SHALL decrement by 1; if bit_idx == 0 (slot end), bit_idx SHALL wrap to 7 and cur_byte SHALL be reloaded per REQ-015..017.
REQ-015 Slot end in SYNC: cur_byte <= 0xBC; comma_cnt increments; if comma_cnt+1 == SYNC_COMMAS, state SHALL become ACTIVE and this reload SHALL instead follow REQ-016/017.
REQ-016 Slot end in ACTIVE (incl. the transition edge of REQ-015) with FIFO non-empty: cur_byte <= FIFO head, head popped, byte_sent <= 1.
REQ-017 Slot end in ACTIVE with FIFO empty: cur_byte <= 0xBC idle comma, byte_sent <= 0.
REQ-018 byte_sent SHALL be 0 on every edge other than those in REQ-016.
REQ-019 Simultaneous push and pop on the same edge SHALL leave occupancy unchanged and preserve order; push when occupancy 2 cannot occur (in_ready=0).
REQ-020 in_data = 0xBC SHALL be accepted and transmitted as a data byte (byte_sent pulses); no escaping.
REQ-021 Latency: a byte popped at slot-end edge E SHALL appear on data_out at edges E+1 (bit 7) through E+8 (bit 0).
REQ-022 synced SHALL be 1 iff state == ACTIVE; it never returns to 0 except by reset.
REQ-023 Stream SHALL be gap-free: exactly one bit per edge, byte boundaries every 8 edges, from the first edge after reset release.

Reset
REQ-024 While reset=1 at an edge: state=SYNC, comma_cnt=0, bit_idx=7, cur_byte=0xBC, FIFO emptied, data_out=0, byte_sent=0, synced=0.
REQ-025 in_ready SHALL be 1 in the cycle after reset; in_valid during a reset edge SHALL be ignored.
REQ-026 Reset asserted mid-byte or mid-SYNC SHALL discard the partial byte and FIFO contents and restart SYNC from the next non-reset edge.

Verification
REQ-027 Reset, then in_valid=0 for 64 edges -> data_out on edges 1..64 = repeating 1,0,1,1,1,1,0,0; synced rises after edge 32; byte_sent never pulses.
REQ-028 Push 0xA5 at edge 3 (during SYNC) -> byte_sent pulses after edge 32; data_out edges 33..40 = 1,0,1,0,0,1,0,1; then 0xBC pattern resumes.
REQ-029 After synced, hold in_valid=1 with 0x01,0x02,0x03,0x04 -> in_ready drops when occupancy hits 2, stays low until next slot-end pop; bytes emerge in order with no gaps or comma between them.
REQ-030 Assert reset at edge 37 (mid data byte) for one edge -> data_out=0 next cycle, synced=0, FIFO empty, 0xBC pattern restarts; synced again 32 edges after release.
REQ-031 Push 0xBC after synced -> byte_sent pulses on its slot-end edge; serialized bits 1,0,1,1,1,1,0,0.
REQ-032 SYNC_COMMAS=1, push 0x3C at edge 1 -> synced after edge 8; data_out edges 9..16 = 0,0,1,1,1,1,0,0.

Source files
------------

// File: rtl/paralelo_serie_tx.sv
// Parallel-to-serial transmitter: emits SYNC_COMMAS 0xBC commas after reset, then
// serializes bytes from a 2-entry FIFO MSB first, filling empty slots with 0xBC.
module paralelo_serie_tx #(
    parameter int SYNC_COMMAS = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       data_out,
    output logic       synced,
    output logic       byte_sent
);

    localparam logic [7:0] COMMA      = 8'hBC;
    localparam logic [2:0] LAST_COMMA = 3'(SYNC_COMMAS - 1);

    typedef enum logic {SYNC, ACTIVE} state_t;

    state_t     state, state_nx;
    logic [7:0] cur_byte;
    logic [2:0] bit_idx;
    logic [2:0] comma_cnt;
    logic [7:0] fifo_mem [2];
    logic       rd_ptr, wr_ptr;
    logic [1:0] occ;
    logic       slot_end, load_active, push, pop;

    // Handshake: a byte transfers on any rising edge where in_valid and in_ready are
    // both high; in_ready depends only on registered occupancy, never on in_valid.
    assign in_ready = (occ < 2'd2);
    assign synced   = (state == ACTIVE);

    always_comb begin
        state_nx    = state;
        load_active = 1'b0;
        slot_end    = (bit_idx == 3'd0);
        if (slot_end) begin
            if (state == ACTIVE) begin
                load_active = 1'b1;
            end else if (comma_cnt == LAST_COMMA) begin
                // The final sync comma ends here, so this slot already carries data.
                state_nx    = ACTIVE;
                load_active = 1'b1;
            end
        end
        push = in_valid && in_ready;
        pop  = load_active && (occ != 2'd0);
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            state <= SYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_8f) begin
        if (reset) begin
            comma_cnt <= 3'd0;
            bit_idx   <= 3'd7;
            cur_byte  <= COMMA;
            data_out  <= 1'b0;
            byte_sent <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
        end else begin
            data_out  <= cur_byte[bit_idx];
            byte_sent <= pop;
            if (!slot_end) begin
                bit_idx <= bit_idx - 3'd1;
            end else begin
                bit_idx <= 3'd7;
                if (state == SYNC) begin
                    comma_cnt <= comma_cnt + 3'd1;
                end
                cur_byte <= pop ? fifo_mem[rd_ptr] : COMMA;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk_8f) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_paralelo_serie_tx.sv
// Bench for paralelo_serie_tx: byte-level scoreboard of the FIFO plus a serial
// receiver that rebuilds each 8-bit slot and compares it against the expected byte.
module tb_paralelo_serie_tx;

    localparam int         SC    = 4;
    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk_8f = 1'b0;
    logic       reset, in_valid, in_ready, data_out, synced, byte_sent;
    logic [7:0] in_data;
    logic       reset_1, in_valid_1, in_ready_1, data_out_1, synced_1, byte_sent_1;
    logic [7:0] in_data_1;

    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cur_exp;
    logic [7:0] rx;

    always #5 clk_8f = ~clk_8f;

    paralelo_serie_tx #(.SYNC_COMMAS(SC)) u_dut (
        .clk_8f(clk_8f), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .synced(synced), .byte_sent(byte_sent)
    );

    paralelo_serie_tx #(.SYNC_COMMAS(1)) u_dut_1 (
        .clk_8f(clk_8f), .reset(reset_1), .in_data(in_data_1), .in_valid(in_valid_1),
        .in_ready(in_ready_1), .data_out(data_out_1), .synced(synced_1), .byte_sent(byte_sent_1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    // One edge of the main DUT: predicted pop happens before the push on the same edge.
    task automatic step();
        logic       took;
        logic       exp_sent;
        logic [7:0] d;
        took = in_valid && (exp_q.size() < 2);
        d    = in_data;
        @(posedge clk_8f);
        #1;
        edge_n++;
        rx       = {rx[6:0], data_out};
        exp_sent = 1'b0;
        if (edge_n % 8 == 0) begin
            check("serial_byte", rx, cur_exp);
            if (edge_n >= 8 * SC && exp_q.size() > 0) begin
                cur_exp  = exp_q.pop_front();
                exp_sent = 1'b1;
            end else begin
                cur_exp = COMMA;
            end
        end
        if (took) exp_q.push_back(d);
        check("byte_sent", byte_sent, exp_sent);
        check("synced", synced, edge_n >= 8 * SC);
        check("in_ready", in_ready, exp_q.size() < 2);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push_at(input int e, input logic [7:0] d);
        while (edge_n < e - 1) step();
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    // in_valid is held high across reset edges; those bytes must be dropped.
    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        repeat (n) @(posedge clk_8f);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_synced", synced, 0);
        check("rst_byte_sent", byte_sent, 0);
        check("rst_in_ready", in_ready, 1);
        reset    = 1'b0;
        in_valid = 1'b0;
        edge_n   = 0;
        rx       = 8'h00;
        cur_exp  = COMMA;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  burst [4];
        logic [15:0] rx1;
        int          idx;
        int          guard;
        logic        accepted;

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        reset_1 = 1'b1; in_valid_1 = 1'b0; in_data_1 = 8'h00;
        cur_exp = COMMA; rx = 8'h00;

        // Idle stream: commas only, synced after edge 32, no byte_sent
        do_reset(3);
        run(64);

        // Byte pushed during SYNC appears right after the last sync comma
        do_reset(2);
        push_at(3, 8'hA5);
        while (edge_n < 56) step();

        // Back-to-back burst: in_ready throttles, bytes leave in consecutive slots
        burst[0] = 8'h01; burst[1] = 8'h02; burst[2] = 8'h03; burst[3] = 8'h04;
        idx = 0;
        guard = 0;
        while (idx < 4 && guard < 100) begin
            in_valid = 1'b1;
            in_data  = burst[idx];
            accepted = (exp_q.size() < 2);
            step();
            if (accepted) idx++;
            guard++;
        end
        in_valid = 1'b0;
        check("burst_done", idx, 4);
        run(40);

        // A data byte equal to the comma value is sent as data
        in_valid = 1'b1;
        in_data  = COMMA;
        step();
        in_valid = 1'b0;
        run(24);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = ($urandom_range(0, 7) == 0) ? COMMA : 8'($urandom_range(0, 255));
            step();
        end
        in_valid = 1'b0;
        run(40);

        // Reset mid data byte with a byte still queued: everything is discarded
        do_reset(1);
        push_at(3, 8'h5A);
        push_at(4, 8'h77);
        push_at(5, 8'h11);
        while (edge_n < 36) step();
        do_reset(1);
        run(48);

        // Single sync comma: data byte follows the first comma directly
        reset_1 = 1'b1;
        repeat (2) @(posedge clk_8f);
        #1;
        reset_1    = 1'b0;
        in_valid_1 = 1'b1;
        in_data_1  = 8'h3C;
        rx1        = 16'h0000;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk_8f);
            #1;
            if (e == 1) in_valid_1 = 1'b0;
            rx1 = {rx1[14:0], data_out_1};
            if (e == 7) check("sc1_synced_early", synced_1, 0);
            if (e == 8) begin
                check("sc1_synced", synced_1, 1);
                check("sc1_byte_sent", byte_sent_1, 1);
            end
        end
        check("sc1_stream", rx1, 16'hBC3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
